// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and boot status of the program loader.
interface imem_loader_if #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 10
);
   logic                  start;
   logic                  byte_valid;
   logic [7:0]            byte_data;
   logic                  byte_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [WIDTH-1:0]      imem_wdata;
   logic                  cpu_hold;
   logic                  done;
   logic                  error;

   modport master (
      output start, byte_valid, byte_data,
      input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
   );

   modport slave (
      input  start, byte_valid, byte_data,
      output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses a length/data/checksum byte frame, writes words into instruction
// memory and keeps the CPU in reset until the image checksum has been verified.
module imem_loader #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int TIMEOUT    = 1000
) (
   input  logic          clk,
   input  logic          reset,
   imem_loader_if.slave  bus
);
   localparam int          DEPTH   = 2 ** ADDR_WIDTH;
   localparam int          IDLE_W  = $clog2(TIMEOUT + 1);
   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
   } state_t;

   state_t                r_state, w_next;
   logic [15:0]           r_len;
   logic [15:0]           r_wordCnt;
   logic [1:0]            r_byteIdx;
   logic [WIDTH-1:0]      r_word;
   logic [7:0]            r_csum;
   logic [IDLE_W-1:0]     r_idle;

   logic                  r_byteReady, r_we, r_done, r_error, r_hold;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [WIDTH-1:0]      r_wdata;

   logic                  w_xfer, w_receiving, w_nextReceiving, w_timeout, w_we, w_enterLen;
   logic [15:0]           w_lenFull;
   logic [WIDTH-1:0]      w_word;

   assign bus.byte_ready = r_byteReady;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign bus.cpu_hold   = r_hold;
   assign bus.done       = r_done;
   assign bus.error      = r_error;

   // Next-state decode; the idle timeout overrides any other transition.
   always_comb begin
      w_next          = r_state;
      w_word          = r_word;
      w_xfer          = bus.byte_valid & r_byteReady;
      w_lenFull       = {bus.byte_data, r_len[7:0]};
      w_receiving     = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA)   || (r_state == S_CSUM);
      w_timeout       = w_receiving && !w_xfer && (r_idle == IDLE_W'(TIMEOUT - 1));
      w_we            = (r_state == S_DATA) && w_xfer && (r_byteIdx == 2'd3);
      w_word[8*r_byteIdx +: 8] = bus.byte_data;

      case (r_state)
         S_IDLE:   if (bus.start) w_next = S_LEN_LO;
         S_LEN_LO: if (w_xfer) w_next = S_LEN_HI;
         S_LEN_HI: if (w_xfer) begin
            if ({1'b0, w_lenFull} > DEPTH_L) w_next = S_ERROR;
            else if (w_lenFull == 16'd0)     w_next = S_CSUM;
            else                             w_next = S_DATA;
         end
         S_DATA:   if (w_we && (r_wordCnt == r_len - 16'd1)) w_next = S_CSUM;
         S_CSUM:   if (w_xfer) w_next = (bus.byte_data == r_csum) ? S_DONE : S_ERROR;
         S_DONE:   if (bus.start) w_next = S_LEN_LO;
         S_ERROR:  if (bus.start) w_next = S_LEN_LO;
         default:  w_next = S_IDLE;
      endcase
      if (w_timeout) w_next = S_ERROR;

      w_nextReceiving = (w_next == S_LEN_LO) || (w_next == S_LEN_HI) ||
                        (w_next == S_DATA)   || (w_next == S_CSUM);
      w_enterLen      = (w_next == S_LEN_LO) && (r_state != S_LEN_LO);
   end

   // State and registered outputs, all derived from the upcoming state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_byteReady <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_hold      <= 1'b1;
      end else begin
         r_state     <= w_next;
         r_byteReady <= w_nextReceiving;
         r_we        <= w_we;
         r_done      <= (w_next == S_DONE);
         r_error     <= (w_next == S_ERROR);
         r_hold      <= (w_next != S_DONE);
         if (w_we) begin
            r_addr  <= r_wordCnt[ADDR_WIDTH-1:0];
            r_wdata <= w_word;
         end
      end
   end

   // Frame datapath: length capture, word assembly, running checksum and idle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_len     <= '0;
         r_wordCnt <= '0;
         r_byteIdx <= '0;
         r_word    <= '0;
         r_csum    <= '0;
         r_idle    <= '0;
      end else if (w_enterLen) begin
         r_wordCnt <= '0;
         r_byteIdx <= '0;
         r_csum    <= '0;
         r_idle    <= '0;
      end else begin
         if (w_receiving) r_idle <= w_xfer ? '0 : r_idle + 1'b1;
         if (w_xfer) begin
            case (r_state)
               S_LEN_LO: r_len[7:0]  <= bus.byte_data;
               S_LEN_HI: r_len[15:8] <= bus.byte_data;
               S_DATA: begin
                  r_word    <= w_word;
                  r_csum    <= r_csum ^ bus.byte_data;
                  r_byteIdx <= r_byteIdx + 2'd1;
                  if (r_byteIdx == 2'd3) r_wordCnt <= r_wordCnt + 16'd1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule
